// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, funct3 codes and FSM state encoding for the load/store unit
package lsu_pkg;

   localparam int DATA_WIDTH = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_MERGE = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   function automatic logic f3_legal(input logic [2:0] f3, input logic we);
      case (f3)
         F3_B, F3_H, F3_W: f3_legal = 1'b1;
         F3_BU, F3_HU:     f3_legal = !we;
         default:          f3_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - byte/half lane extraction with sign/zero extension and sub-word store merge
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] word_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [1:0]            off_i,
   input  logic [2:0]            funct3_i,
   output logic [DATA_WIDTH-1:0] load_o,
   output logic [DATA_WIDTH-1:0] merge_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = word_i[{off_i, 3'b000} +: 8];
   assign half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

   always_comb begin
      load_o = word_i;
      case (funct3_i)
         F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_o = {24'b0, byte_sel};
         F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_o = {16'b0, half_sel};
         default: load_o = word_i;
      endcase
   end

   always_comb begin
      merge_o = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            merge_o = word_i;
            merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         2'b01:   merge_o = off_i[1] ? {wdata_i[15:0], word_i[15:0]}
                                     : {word_i[31:16], wdata_i[15:0]};
         default: merge_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - MEM-stage load/store unit with read-modify-write for sub-word stores
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them.
module lsu_rmw
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [31:0]           req_addr_i,
   input  logic [31:0]           req_wdata_i,
   input  logic [2:0]            req_funct3_i,
   output logic                  rsp_valid_o,
   output logic [31:0]           rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_din_o,
   input  logic [31:0]           mem_dout_i
);

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [2:0]            f3_q, f3_d;
   logic [1:0]            off_q, off_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [31:0]           wbuf_q, wbuf_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic                  acc_err;
   logic [1:0]            acc_off;
   logic [31:0]           load_word;
   logic [31:0]           merge_word;
   logic                  unused_addr_hi;

   // Address bits above the memory are intentionally dropped (wrap-around).
   assign unused_addr_hi = ^req_addr_i[31:ADDR_WIDTH+2];

   always_comb begin
      acc_err = !f3_legal(req_funct3_i, req_we_i);
      acc_off = req_addr_i[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
      if ((req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
          (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00)) begin
         acc_err = 1'b1;
      end
`else
      case (req_funct3_i[1:0])
         2'b01:   acc_off = {req_addr_i[1], 1'b0};
         2'b10:   acc_off = 2'b00;
         default: acc_off = req_addr_i[1:0];
      endcase
`endif
   end

   lsu_byte_lane u_lane (
      .word_i   (mem_dout_i),
      .wdata_i  (wbuf_q),
      .off_i    (off_q),
      .funct3_i (f3_q),
      .load_o   (load_word),
      .merge_o  (merge_word)
   );

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      off_d   = off_q;
      waddr_d = waddr_q;
      wbuf_d  = wbuf_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               we_d    = req_we_i;
               f3_d    = req_funct3_i;
               off_d   = acc_off;
               waddr_d = req_addr_i[ADDR_WIDTH+1:2];
               wbuf_d  = req_wdata_i;
               rdata_d = 32'b0;
               err_d   = acc_err;
               if (acc_err)
                  state_d = ST_DONE;
               else if (req_we_i && req_funct3_i == F3_W)
                  state_d = ST_WRITE;
               else
                  state_d = ST_READ;
            end
         end
         ST_READ:  state_d = ST_MERGE;
         ST_MERGE: begin
            if (we_q) begin
               wbuf_d  = merge_word;
               state_d = ST_WRITE;
            end else begin
               rdata_d = load_word;
               state_d = ST_DONE;
            end
         end
         ST_WRITE: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b0;
         off_q   <= 2'b0;
         waddr_q <= '0;
         wbuf_q  <= 32'b0;
         rdata_q <= 32'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         waddr_q <= waddr_d;
         wbuf_q  <= wbuf_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign rsp_valid_o = (state_q == ST_DONE);
   assign rsp_rdata_o = (state_q == ST_DONE) ? rdata_q : 32'b0;
   assign rsp_err_o   = (state_q == ST_DONE) && err_q;
   // Gating with rst keeps an abandoned RMW from touching memory.
   assign mem_we_o    = (state_q == ST_WRITE) && !rst_i;
   assign mem_addr_o  = waddr_q;
   assign mem_din_o   = wbuf_q;

endmodule
